// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared constants, state type and parameter check for the strobe decoder
//
// Purpose: common definitions imported by the strobe decoder interface,
// the index-to-one-hot helper and the top-level sequencer.
// Contents: CODE_W / OUT_W widths, state_e FSM encoding, params_legal().
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Hold must be at least one cycle; both durations must fit the 8-bit counter.
  function automatic bit params_legal(input int hold_cycles, input int gap_cycles);
    return (hold_cycles >= 1) && (hold_cycles <= 255) &&
           (gap_cycles >= 0) && (gap_cycles <= 255);
  endfunction

endpackage

// File: rtl/strobe_decoder_3x8_if.sv
// rtl/strobe_decoder_3x8_if.sv - code handshake and strobe bundle for the strobe decoder
//
// Purpose: groups the code input handshake, cancel and strobe outputs.
// Signals: in_valid/in_ready handshake, a/b/c code (a = MSB), abort cancel,
//          d one-hot strobe, busy, done pulse.
// Modports: master drives codes and abort; slave is the decoder itself.
interface strobe_decoder_3x8_if;

  logic                         in_valid;
  logic                         in_ready;
  logic                         a;
  logic                         b;
  logic                         c;
  logic                         abort;
  logic [decoder_pkg::OUT_W-1:0] d;
  logic                         busy;
  logic                         done;

  modport master (
    output in_valid, a, b, c, abort,
    input  in_ready, d, busy, done
  );

  modport slave (
    input  in_valid, a, b, c, abort,
    output in_ready, d, busy, done
  );

endinterface

// File: rtl/decoder_3x8_comb.sv
// rtl/decoder_3x8_comb.sv - combinational 3-bit index to 8-bit one-hot conversion
//
// Purpose: pure index-to-one-hot decode; the caller registers the result.
// Ports: idx   input  CODE_W  binary index
//        onehot output OUT_W  onehot[idx] = 1, all other bits 0
module decoder_3x8_comb
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] idx,
  output logic [OUT_W-1:0]  onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/strobe_decoder_3x8.sv
// rtl/strobe_decoder_3x8.sv - sequenced 3-to-8 strobe decoder with one-entry pending register
//
// Purpose: accepts 3-bit codes over a valid/ready handshake, drives the matching
// one-hot line of d for HOLD_CYCLES, then zero for GAP_CYCLES. One code may wait
// in a pending register so back-to-back codes run without idle bubbles.
// Ports: clk  rising-edge clock
//        rst  synchronous active-high reset
//        bus  strobe_decoder_3x8_if.slave (in_valid/in_ready, a/b/c, abort, d, busy, done)
module strobe_decoder_3x8
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input logic                  clk,
  input logic                  rst,
  strobe_decoder_3x8_if.slave  bus
);

  if (!params_legal(HOLD_CYCLES, GAP_CYCLES)) begin : g_bad_params
    $error("strobe_decoder_3x8: HOLD_CYCLES must be 1..255 and GAP_CYCLES 0..255");
  end

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  // Unused when GAP_CYCLES == 0; the gap branch is never taken then.
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic [OUT_W-1:0]    d_q, d_d;

  logic [CODE_W-1:0]   code_in;
  logic                in_ready;
  logic                xfer;
  logic                complete;
  logic [OUT_W-1:0]    onehot;

  assign code_in  = {bus.a, bus.b, bus.c};
  assign in_ready = !pend_valid_q && !bus.abort && !rst;
  assign xfer     = bus.in_valid && in_ready;

  // Decode the code that will be live next cycle so d can be a plain register.
  decoder_3x8_comb u_dec (
    .idx    (code_d),
    .onehot (onehot)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    complete     = 1'b0;

    if (bus.abort) begin
      // Drops both the running and the queued code; pend value itself is kept.
      state_d      = IDLE;
      cnt_d        = '0;
      pend_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            state_d = HOLD;
            code_d  = code_in;
            cnt_d   = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              cnt_d   = GAP_LOAD;
              if (xfer) begin
                pend_d       = code_in;
                pend_valid_d = 1'b1;
              end
            end else begin
              complete = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
            if (xfer) begin
              pend_d       = code_in;
              pend_valid_d = 1'b1;
            end
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            complete = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
            if (xfer) begin
              pend_d       = code_in;
              pend_valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // Queued code wins; otherwise a code arriving now bypasses the pend slot.
      if (complete) begin
        if (pend_valid_q) begin
          state_d      = HOLD;
          code_d       = pend_q;
          cnt_d        = HOLD_LOAD;
          pend_valid_d = 1'b0;
        end else if (xfer) begin
          state_d = HOLD;
          code_d  = code_in;
          cnt_d   = HOLD_LOAD;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end

    d_d = (state_d == HOLD) ? onehot : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      d_q          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      d_q          <= d_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.d        = d_q;
  assign bus.busy     = (state_q != IDLE);
  // Masked by abort/rst so a cancel in the last hold cycle yields no pulse.
  assign bus.done     = (state_q == HOLD) && (cnt_q == '0) && !bus.abort && !rst;

endmodule

// File: tb/tb_strobe_decoder_3x8.sv
// tb/tb_strobe_decoder_3x8.sv - directed self-checking bench for strobe_decoder_3x8
module tb_strobe_decoder_3x8;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  strobe_decoder_3x8_if ifa ();
  strobe_decoder_3x8_if ifb ();

  strobe_decoder_3x8 #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  strobe_decoder_3x8 #(.HOLD_CYCLES(2), .GAP_CYCLES(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [2:0] code);
    ifa.in_valid = 1'b1;
    {ifa.a, ifa.b, ifa.c} = code;
    step();
    ifa.in_valid = 1'b0;
  endtask

  // Reference 8x3 encoder: one-hot in, binary index out.
  function automatic logic [2:0] enc8x3(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ifa.in_valid = 1'b1; {ifa.a, ifa.b, ifa.c} = 3'd5;
    ifb.in_valid = 1'b1; {ifb.a, ifb.b, ifb.c} = 3'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (ifa.d !== 8'h00) $display("FAIL reset_d cyc%0d got %h exp 00", i, ifa.d); else pass_cnt++;
      total_cnt++; if (ifa.busy !== 1'b0) $display("FAIL reset_busy cyc%0d got %b exp 0", i, ifa.busy); else pass_cnt++;
      total_cnt++; if (ifa.done !== 1'b0) $display("FAIL reset_done cyc%0d got %b exp 0", i, ifa.done); else pass_cnt++;
      total_cnt++; if (ifa.in_ready !== 1'b0) $display("FAIL reset_ready_low cyc%0d got %b exp 0", i, ifa.in_ready); else pass_cnt++;
    end
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    ifb.in_valid = 1'b0;
    #1;
    total_cnt++; if (ifa.in_ready !== 1'b1) $display("FAIL reset_ready_a got %b exp 1", ifa.in_ready); else pass_cnt++;
    total_cnt++; if (ifb.in_ready !== 1'b1) $display("FAIL reset_ready_b got %b exp 1", ifb.in_ready); else pass_cnt++;
    step();
    total_cnt++; if (ifa.busy !== 1'b0) $display("FAIL reset_no_xfer busy got %b exp 0", ifa.busy); else pass_cnt++;
    total_cnt++; if (ifb.busy !== 1'b0) $display("FAIL reset_no_xfer_b busy got %b exp 0", ifb.busy); else pass_cnt++;
  endtask

  task automatic test_all_codes();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int k = 0; k < 8; k++) begin
      send_a(3'(k));
      for (int i = 1; i <= 4; i++) begin
        total_cnt++; if (ifa.d !== exp_tab[k]) $display("FAIL codes_d code%0d cyc%0d got %h exp %h", k, i, ifa.d, exp_tab[k]); else pass_cnt++;
        total_cnt++; if (ifa.done !== (i == 4)) $display("FAIL codes_done code%0d cyc%0d got %b exp %b", k, i, ifa.done, (i == 4)); else pass_cnt++;
        total_cnt++; if (ifa.busy !== 1'b1) $display("FAIL codes_busy code%0d cyc%0d got %b exp 1", k, i, ifa.busy); else pass_cnt++;
        step();
      end
      total_cnt++; if (ifa.d !== 8'h00) $display("FAIL codes_gap_d code%0d got %h exp 00", k, ifa.d); else pass_cnt++;
      total_cnt++; if (ifa.done !== 1'b0) $display("FAIL codes_gap_done code%0d got %b exp 0", k, ifa.done); else pass_cnt++;
      total_cnt++; if (ifa.busy !== 1'b1) $display("FAIL codes_gap_busy code%0d got %b exp 1", k, ifa.busy); else pass_cnt++;
      step();
      total_cnt++; if (ifa.busy !== 1'b0) $display("FAIL codes_idle_busy code%0d got %b exp 0", k, ifa.busy); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d_exp    [9];
    logic       done_exp [9];
    logic       rdy_exp  [9];
    logic       busy_exp [9];
    logic       vld_tab  [9];
    logic [2:0] code_tab [9];
    d_exp    = '{8'h08, 8'h08, 8'h20, 8'h20, 8'h40, 8'h40, 8'h02, 8'h02, 8'h00};
    done_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rdy_exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    busy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vld_tab  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    code_tab = '{3'd5, 3'd6, 3'd6, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
    ifb.in_valid = 1'b1;
    {ifb.a, ifb.b, ifb.c} = 3'd3;
    step();
    for (int i = 0; i < 9; i++) begin
      total_cnt++; if (ifb.d !== d_exp[i]) $display("FAIL b2b_d cyc%0d got %h exp %h", i + 1, ifb.d, d_exp[i]); else pass_cnt++;
      total_cnt++; if (ifb.done !== done_exp[i]) $display("FAIL b2b_done cyc%0d got %b exp %b", i + 1, ifb.done, done_exp[i]); else pass_cnt++;
      total_cnt++; if (ifb.in_ready !== rdy_exp[i]) $display("FAIL b2b_ready cyc%0d got %b exp %b", i + 1, ifb.in_ready, rdy_exp[i]); else pass_cnt++;
      total_cnt++; if (ifb.busy !== busy_exp[i]) $display("FAIL b2b_busy cyc%0d got %b exp %b", i + 1, ifb.busy, busy_exp[i]); else pass_cnt++;
      ifb.in_valid = vld_tab[i];
      {ifb.a, ifb.b, ifb.c} = code_tab[i];
      step();
    end
    ifb.in_valid = 1'b0;
  endtask

  task automatic test_encoder_roundtrip();
    logic [7:0] rt_tab [8];
    rt_tab = '{8'h10, 8'h01, 8'h80, 8'h02, 8'h40, 8'h04, 8'h20, 8'h08};
    for (int k = 0; k < 8; k++) begin
      send_a(enc8x3(rt_tab[k]));
      for (int i = 1; i <= 4; i++) begin
        total_cnt++; if (ifa.d !== rt_tab[k]) $display("FAIL roundtrip_d vec%0d cyc%0d got %h exp %h", k, i, ifa.d, rt_tab[k]); else pass_cnt++;
        step();
      end
      step();
    end
  endtask

  task automatic test_abort();
    send_a(3'd2);
    total_cnt++; if (ifa.d !== 8'h04) $display("FAIL abort_first_d got %h exp 04", ifa.d); else pass_cnt++;
    ifa.in_valid = 1'b1;
    {ifa.a, ifa.b, ifa.c} = 3'd7;
    step();
    ifa.in_valid = 1'b0;
    total_cnt++; if (ifa.in_ready !== 1'b0) $display("FAIL abort_pend_full ready got %b exp 0", ifa.in_ready); else pass_cnt++;
    step();
    step();
    total_cnt++; if (ifa.done !== 1'b1) $display("FAIL abort_pre_done got %b exp 1", ifa.done); else pass_cnt++;
    ifa.abort = 1'b1;
    #1;
    total_cnt++; if (ifa.done !== 1'b0) $display("FAIL abort_done_masked got %b exp 0", ifa.done); else pass_cnt++;
    total_cnt++; if (ifa.in_ready !== 1'b0) $display("FAIL abort_ready got %b exp 0", ifa.in_ready); else pass_cnt++;
    step();
    ifa.abort = 1'b0;
    #1;
    total_cnt++; if (ifa.d !== 8'h00) $display("FAIL abort_d got %h exp 00", ifa.d); else pass_cnt++;
    total_cnt++; if (ifa.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", ifa.busy); else pass_cnt++;
    total_cnt++; if (ifa.in_ready !== 1'b1) $display("FAIL abort_ready_after got %b exp 1", ifa.in_ready); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++; if (ifa.d !== 8'h00) $display("FAIL abort_no_pend_d cyc%0d got %h exp 00", i, ifa.d); else pass_cnt++;
      total_cnt++; if (ifa.busy !== 1'b0) $display("FAIL abort_no_pend_busy cyc%0d got %b exp 0", i, ifa.busy); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    send_a(3'd3);
    ifa.in_valid = 1'b1;
    {ifa.a, ifa.b, ifa.c} = 3'd6;
    step();
    ifa.in_valid = 1'b0;
    step();
    step();
    step();
    total_cnt++; if (ifa.d !== 8'h00) $display("FAIL rstmid_gap_d got %h exp 00", ifa.d); else pass_cnt++;
    total_cnt++; if (ifa.busy !== 1'b1) $display("FAIL rstmid_gap_busy got %b exp 1", ifa.busy); else pass_cnt++;
    total_cnt++; if (ifa.in_ready !== 1'b0) $display("FAIL rstmid_gap_ready got %b exp 0", ifa.in_ready); else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++; if (ifa.d !== 8'h00) $display("FAIL rstmid_d got %h exp 00", ifa.d); else pass_cnt++;
    total_cnt++; if (ifa.busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", ifa.busy); else pass_cnt++;
    total_cnt++; if (ifa.done !== 1'b0) $display("FAIL rstmid_done got %b exp 0", ifa.done); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (ifa.in_ready !== 1'b1) $display("FAIL rstmid_ready got %b exp 1", ifa.in_ready); else pass_cnt++;
    send_a(3'd1);
    total_cnt++; if (ifa.d !== 8'h02) $display("FAIL rstmid_new_d got %h exp 02", ifa.d); else pass_cnt++;
    total_cnt++; if (ifa.busy !== 1'b1) $display("FAIL rstmid_new_busy got %b exp 1", ifa.busy); else pass_cnt++;
    for (int i = 0; i < 5; i++) step();
    total_cnt++; if (ifa.busy !== 1'b0) $display("FAIL rstmid_drain_busy got %b exp 0", ifa.busy); else pass_cnt++;
    total_cnt++; if (ifa.d !== 8'h00) $display("FAIL rstmid_drain_d got %h exp 00", ifa.d); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.a = 1'b0; ifa.b = 1'b0; ifa.c = 1'b0; ifa.abort = 1'b0;
    ifb.in_valid = 1'b0; ifb.a = 1'b0; ifb.b = 1'b0; ifb.c = 1'b0; ifb.abort = 1'b0;
    test_reset();
    test_all_codes();
    test_back_to_back();
    test_encoder_roundtrip();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/strobe_decoder_3x8.md
# strobe_decoder_3x8

Sequenced 3-to-8 decoder: accepts 3-bit codes {a,b,c} over a valid/ready handshake and drives the matching one-hot line of d[7:0] for a fixed number of cycles, followed by an optional all-zero gap. It is the inverse of the team's 8x3 encoder: a code produced by the encoder from a one-hot d returns the same d here. It sits on the select/strobe side of the design, and a one-entry pending register lets it accept back-to-back codes.

## Interface
- HOLD_CYCLES, 4: cycles the one-hot output is held; legal 1..255.
- GAP_CYCLES, 1: all-zero cycles after each hold; legal 0..255.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- abort  input  1  synchronous cancel of the current and pending code.
- in_valid  input  1  code present on a,b,c.
- in_ready  output  1  block can take a code this cycle.
- a  input  1  code MSB (index bit 2).
- b  input  1  index bit 1.
- c  input  1  code LSB (index bit 0).
- d  output  8  one-hot strobe: d[{a,b,c}] = 1 during HOLD, otherwise 0.
- busy  output  1  high while state != IDLE.
- done  output  1  single-cycle pulse in the last HOLD cycle of each code.

One clock; reset is synchronous and active-high.

## Operation
- **Handshake:** transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = !pend_valid && !abort && !rst.
  - a, b, c only need to be stable in the transfer cycle.
- **FSM states:** IDLE, HOLD, GAP. One counter, width 8.
- **IDLE:** on a transfer, go to HOLD, latch the code, load counter = HOLD_CYCLES-1.
- **HOLD:** d is one-hot of the latched code.
  - Counter decrements each cycle.
  - When counter == 0, assert done.
  - Then, if GAP_CYCLES > 0, go to GAP with counter = GAP_CYCLES-1. Otherwise take the completion path.
- **GAP:** d = 0; counter decrements. When counter == 0, take the completion path.
- **Completion path (priority order):**
  1. pend_valid: load the pending code into HOLD and clear pend_valid.
  2. A transfer this cycle: load the input code directly into HOLD (bypass).
  3. Otherwise go to IDLE.
- **Pending register:** a transfer while in HOLD or GAP, and not on the completion cycle, stores the code in pend and sets pend_valid. At most one pending code.
- **abort:** highest priority after rst.
  - Next cycle: state = IDLE, d = 0, pend_valid = 0, busy = 0.
  - No done pulse, even if abort coincides with the last HOLD cycle.
  - No transfer occurs in an abort cycle.
- **Reset mid-operation:** identical to abort, plus the pending code register clears to 0.
- **Reset values:** d = 8'h00, busy = 0, done = 0, state = IDLE, pend_valid = 0. in_ready reads 1 from the first cycle after rst deasserts.
- d is fully registered, so there is no combinational path from a/b/c to d.

## Timing
- Transfer at edge k gives d valid from cycle k+1 through k+HOLD_CYCLES.
- done is high in cycle k+HOLD_CYCLES.
- d = 0 for cycles k+HOLD_CYCLES+1 .. k+HOLD_CYCLES+GAP_CYCLES.
- Back-to-back codes (pending, or bypass on the completion cycle): the next code's HOLD starts at cycle k+HOLD_CYCLES+GAP_CYCLES+1, with no idle bubble.
- With GAP_CYCLES = 0, consecutive codes produce a d change on adjacent cycles with no zero cycle.
- Sustained throughput: one code per HOLD_CYCLES+GAP_CYCLES cycles.
- in_ready drops the cycle after pend is filled and rises the cycle after pend is drained.
- busy rises at k+1 and falls in the first cycle after completion with nothing queued.

## Structure
- Package decoder_pkg holds:
  - CODE_W = 3 and OUT_W = 8 constants.
  - The state enum typedef (IDLE, HOLD, GAP).
  - A parameter-legality check helper.
- Sub-module decoder_3x8_comb: purely combinational index-to-one-hot conversion. It is instantiated once and its output is registered in the top.
- Top strobe_decoder_3x8 contains the FSM, counter, pending register and handshake.

## Test plan
- **Reset:** hold rst 3 cycles with in_valid = 1 → d = 00, busy = 0, done = 0, no transfer; in_ready = 1 the first cycle after release.
- **All codes:** HOLD = 4, GAP = 1; send codes 0..7 singly, spaced apart → d = 01, 02, 04 … 80, each for exactly 4 cycles. done is high in the 4th cycle of each, then d = 0 for 1 cycle.
- **Back-to-back:** HOLD = 2, GAP = 0; keep in_valid high with codes 3, 5, 6 → d = 08, 08, 20, 20, 40, 40 with no zero cycle. in_ready low while pend is full.
- **Encoder round-trip:** drive the 8x3 encoder with d_in = 10, feed its a,b,c here → d = 10 during HOLD. Repeat for all 8 one-hot values.
- **Abort:** abort in the last HOLD cycle of code 2 with code 7 pending → no done pulse; d = 00 and busy = 0 next cycle. Code 7 is never driven.
- **Reset mid-operation:** rst during GAP with a pending code → all outputs at reset values next cycle. A new code 1 after release gives d = 02 at k+1.
